instr_fetch_ctrl: RTL
=====================

Name: instr_fetch_ctrl

Overview:
- Fetch-side controller that consumes the current PC from the program counter and drives that counter's next-value and stall inputs.
- Issues instruction-memory requests over a valid/ready request channel and a valid-only response channel.
- Buffers fetched {pc, instr} pairs for the IF/ID stage.
- Handles branch/jump redirects and load-use stalls from hazard detection.

Parameters:
- ADDR_W, 64, PC and memory address width.
- INSTR_W, 32, instruction width.
- BUF_DEPTH, 2, fetch buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_in  in  ADDR_W  current PC from the program counter.
- pc_next  out  ADDR_W  next-PC value to the program counter.
- stall  out  1  holds the program counter when 1.
- hazard_stall  in  1  load-use stall from hazard detection; blocks new requests.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  request address.
- imem_rsp_valid  in  1  response valid; at least 1 cycle after acceptance; no backpressure.
- imem_rsp_data  in  INSTR_W  fetched instruction.
- id_valid  out  1  buffer head valid.
- id_ready  in  1  decode consumes head.
- id_instr  out  INSTR_W  head instruction.
- id_pc  out  ADDR_W  head PC.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=REQ, buffer count=0, pointers=0, req_pc=0, id_valid=0.
  - imem_req_valid is forced 0 while reset is asserted.
- FSM states:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - DRAIN: outstanding response is to be discarded.
- Maximum outstanding requests: one.
- Request issue:
  - imem_req_valid = (state==REQ) && !redirect_valid && !hazard_stall && (count < BUF_DEPTH).
  - imem_req_addr = pc_in.
- On handshake (valid && ready): req_pc <= pc_in; REQ -> WAIT.
- If not accepted, the request stays asserted with the same address. A request may be withdrawn only by redirect, hazard_stall or reset.
- PC control:
  - stall = !(redirect_valid || (imem_req_valid && imem_req_ready)).
  - pc_next = redirect_valid ? redirect_pc : pc_in + 4, with modulo 2^ADDR_W wrap.
  - Net effect: the PC advances only when a request is accepted or a redirect occurs.
- Response handling:
  - WAIT & imem_rsp_valid: push {req_pc, imem_rsp_data}; WAIT -> REQ.
  - No new request is issued in the response cycle; minimum 2 cycles per fetch.
  - DRAIN & imem_rsp_valid: discard the data; DRAIN -> REQ.
  - imem_rsp_valid in REQ state is ignored. This covers stale responses across reset.
- Push cannot occur when full: issue is gated on count < BUF_DEPTH, with the outstanding request counted, i.e. issue only if count + (state!=REQ) < BUF_DEPTH.
- Decode interface:
  - id_valid = (count != 0); id_instr and id_pc come from the head.
  - Pop on id_valid && id_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (redirect_valid==1), taking priority over everything:
  - Buffer flushed (count=0, pointers=0); a same-cycle pop or push is discarded.
  - No request is issued that cycle.
  - WAIT without same-cycle response -> DRAIN.
  - WAIT with same-cycle response -> REQ, response discarded.
  - DRAIN stays DRAIN; REQ stays REQ.
- hazard_stall: only suppresses new requests. In-flight responses are still accepted into the buffer; pops continue.
- Pointer wrap: pointers are log2(BUF_DEPTH) bits and wrap naturally.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, DRAIN}.
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h00000013 for downstream bubble insertion.
- Sub-module fetch_buffer:
  - Parameterised synchronous FIFO of {pc, instr}.
  - Ports: push/pop/flush, count, head outputs.
  - Asynchronous active-low reset.

Test Plan:
- Reset, pc_in=0, imem_req_ready=1, 1-cycle response latency, id_ready=1 -> requests at 0x0, 0x4, 0x8 every 2 cycles; id_pc sequence 0,4,8 with matching data; pc_next=pc_in+4 on accept cycles; stall=1 otherwise.
- id_ready=0, continuous fetch -> exactly 2 entries buffered; imem_req_valid stays 0 while count+outstanding==2; stall=1; PC frozen at 0x8.
- imem_req_ready=0 for 3 cycles -> req_valid held with addr 0x4 stable; stall=1; PC unchanged until accept.
- Redirect to 0x100 while in WAIT, response arriving 2 cycles later -> response discarded, buffer empty, next request addr=0x100, first id_pc=0x100.
- Redirect in the same cycle as a response and a pop with count=1 -> buffer empty next cycle, state REQ, no push, pc_next=redirect_pc, stall=0.
- hazard_stall=1 while WAIT -> response still pushed; no new request until hazard_stall=0. Then assert reset mid-WAIT and send a stale response -> ignored; id_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch slice.
//   fetch_state_t : controller FSM states
//                   REQ   - free to issue a request
//                   WAIT  - one request outstanding, response will be kept
//                   DRAIN - one request outstanding, response will be dropped
//   INSTR_BYTES   : sequential PC increment
//   NOP_INSTR     : canonical bubble (addi x0,x0,0) for downstream stages
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam int INSTR_BYTES = 4;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Small synchronous FIFO holding fetched {pc, instr} pairs between the fetch
// controller and decode. DEPTH must be a power of two (>= 2) so that the
// read/write pointers can simply wrap at their natural width.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   flush      in   empties the buffer; wins over push/pop in the same cycle
//   push       in   write {push_pc, push_instr} at the tail
//   push_pc    in   PC of the entry being written
//   push_instr in   instruction of the entry being written
//   pop        in   drop the head entry
//   count      out  number of valid entries (0..DEPTH)
//   head_pc    out  PC of the head entry
//   head_instr out  instruction of the head entry
// ---------------------------------------------------------------------------
module fetch_buffer #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        push_pc,
   input  logic [INSTR_W-1:0]       push_instr,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic [ADDR_W-1:0]        head_pc,
   output logic [INSTR_W-1:0]       head_instr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0]  pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               is_empty;
   logic               is_full;
   logic               pop_ok;
   logic               push_ok;

   // Guard the FIFO against misuse by the caller: a pop of an empty buffer
   // is ignored, and a push into a full buffer only lands if the head is
   // leaving in the same cycle. Flush suppresses both.
   assign is_empty = (count == '0);
   assign is_full  = (count == CNT_W'(DEPTH));
   assign pop_ok   = pop && !is_empty && !flush;
   assign push_ok  = push && (!is_full || pop_ok) && !flush;

   // Pointer and occupancy bookkeeping. Pointers are exactly log2(DEPTH)
   // bits wide so incrementing past the last slot wraps back to slot 0.
   // A simultaneous push and pop moves both pointers but leaves count alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage. No reset is needed here: an entry is only ever observed
   // once count says it was written.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

   assign head_pc    = pc_mem[rd_ptr];
   assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
// Fetch-side controller. Reads the current PC from the program counter,
// issues at most one instruction-memory request at a time, buffers returned
// {pc, instr} pairs for IF/ID, and steers the program counter (advance on an
// accepted request, jump on a redirect, hold otherwise).
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-low reset
//   pc_in          in   current PC from the program counter
//   pc_next        out  next-PC value for the program counter
//   stall          out  1 = program counter holds its value
//   hazard_stall   in   load-use stall; blocks new requests only
//   redirect_valid in   taken branch/jump from EX
//   redirect_pc    in   redirect target
//   imem_req_valid out  request valid
//   imem_req_ready in   memory accepts the request
//   imem_req_addr  out  request address (always pc_in)
//   imem_rsp_valid in   response valid (no backpressure)
//   imem_rsp_data  in   fetched instruction
//   id_valid       out  buffer head valid
//   id_ready       in   decode consumes the head
//   id_instr       out  head instruction
//   id_pc          out  head PC
// ---------------------------------------------------------------------------
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int INSTR_W   = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   pc_in,
   output logic [ADDR_W-1:0]   pc_next,
   output logic                stall,
   input  logic                hazard_stall,
   input  logic                redirect_valid,
   input  logic [ADDR_W-1:0]   redirect_pc,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [ADDR_W-1:0]   imem_req_addr,
   input  logic                imem_rsp_valid,
   input  logic [INSTR_W-1:0]  imem_rsp_data,
   output logic                id_valid,
   input  logic                id_ready,
   output logic [INSTR_W-1:0]  id_instr,
   output logic [ADDR_W-1:0]   id_pc
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_t       state;
   logic [ADDR_W-1:0]  req_pc;
   logic [CNT_W-1:0]   buf_count;
   logic               in_flight;
   logic [CNT_W-1:0]   occupancy;
   logic               has_room;
   logic               req_fire;
   logic               buf_push;
   logic               buf_pop;

   // A request already in flight will land in the buffer, so it has to be
   // counted against free space before another one is allowed out. CNT_W
   // holds BUF_DEPTH+1 because BUF_DEPTH is a power of two.
   assign in_flight = (state != REQ);
   assign occupancy = buf_count + {{(CNT_W-1){1'b0}}, in_flight};
   assign has_room  = (occupancy < CNT_W'(BUF_DEPTH));

   // Request channel. The reset term keeps the memory from seeing a request
   // while the controller is held in reset. Once raised, the request only
   // drops on redirect, hazard_stall or reset; pc_in is frozen by stall, so
   // the address stays stable until accepted.
   assign imem_req_valid = reset && (state == REQ) && !redirect_valid
                           && !hazard_stall && has_room;
   assign imem_req_addr  = pc_in;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Program counter steering: the PC only moves when a request has been
   // accepted (sequential +4, wrapping at 2^ADDR_W) or on a redirect.
   assign stall   = !(redirect_valid || req_fire);
   assign pc_next = redirect_valid ? redirect_pc
                                   : pc_in + ADDR_W'(INSTR_BYTES);

   // Buffer traffic. A redirect flushes the buffer and discards anything
   // that would have entered or left it in the same cycle. Responses seen in
   // REQ (e.g. stale ones from before a reset) or DRAIN never get pushed.
   assign buf_push = (state == WAIT) && imem_rsp_valid && !redirect_valid;
   assign buf_pop  = id_valid && id_ready && !redirect_valid;

   // Controller FSM plus the PC latch for the outstanding request. A
   // response always closes the outstanding request, even in a redirect
   // cycle, which is why the response checks come before the redirect check
   // in WAIT. DRAIN ignores redirect entirely: its outstanding response is
   // already marked for discard, and it must still return to REQ when that
   // response arrives or fetch would deadlock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= REQ;
         req_pc <= '0;
      end else begin
         if (req_fire) begin
            req_pc <= pc_in;
         end
         case (state)
            REQ: begin
               if (req_fire) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  state <= REQ;
               end else if (redirect_valid) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (imem_rsp_valid) begin
                  state <= REQ;
               end
            end
            default: begin
               state <= REQ;
            end
         endcase
      end
   end

   fetch_buffer #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .DEPTH   (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .push       (buf_push),
      .push_pc    (req_pc),
      .push_instr (imem_rsp_data),
      .pop        (buf_pop),
      .count      (buf_count),
      .head_pc    (id_pc),
      .head_instr (id_instr)
   );

   assign id_valid = (buf_count != '0);

endmodule
